serial_add_ctrl: RTL



---
 rtl/serial_add_pkg.sv | 15 +
 rtl/byte_adder_c.sv | 36 +++
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the serial add/subtract controller
package serial_add_pkg;

    localparam int BYTE_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_adder_c.sv
// rtl/byte_adder_c.sv - 8-bit ripple adder with carry in/out built from full-adder cells
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module byte_adder_c
    import serial_add_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [BYTE_W-1:0] o_sum,
    output logic              o_cout
);
    logic [BYTE_W:0] w_carry;

    assign w_carry[0] = i_cin;
    assign o_cout     = w_carry[BYTE_W];

    for (genvar g = 0; g < BYTE_W; g++) begin : g_bit
        full_adder_cell u_fa (
            .i_a    (i_a[g]),
            .i_b    (i_b[g]),
            .i_cin  (w_carry[g]),
            .o_sum  (o_sum[g]),
            .o_cout (w_carry[g+1])
        );
    end
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - WIDTH-bit add/subtract sequenced over one shared byte adder
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N     = WIDTH / BYTE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_c;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_b_eff;
    logic [BYTE_W-1:0]  w_s8;
    logic               w_c8;
    logic [WIDTH+7:0]   w_sum_cat;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_out_fire;

    assign in_ready   = (r_state == IDLE) & ~rst;
    assign w_accept   = in_valid & in_ready;
    assign w_run      = (r_state == RUN);
    assign w_last     = w_run & (r_cnt == CNT_W'(N - 1));
    assign w_out_fire = r_out_valid & out_ready;
    assign w_b_eff    = op ? ~b : b;
    assign w_sum_cat  = {w_s8, r_sum};
    assign w_sum_next = w_sum_cat[WIDTH+7:8];

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    byte_adder_c u_byte_adder (
        .i_a    (r_op_a[BYTE_W-1:0]),
        .i_b    (r_op_b[BYTE_W-1:0]),
        .i_cin  (r_c),
        .o_sum  (w_s8),
        .o_cout (w_c8)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: accept, walk N bytes, then hold until the result is taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_next = RUN;
            RUN:     if (w_last)     w_state_next = DONE;
            DONE:    if (out_ready)  w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    // Datapath: capture operands, shift one byte per RUN cycle, latch flags on the last byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_c         <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= a;
            r_op_b  <= w_b_eff;
            r_c     <= op;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= w_b_eff[WIDTH-1];
        end else if (w_run) begin
            r_op_a <= r_op_a >> BYTE_W;
            r_op_b <= r_op_b >> BYTE_W;
            r_sum  <= w_sum_next;
            r_c    <= w_c8;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout      <= w_c8;
                r_zero      <= (w_sum_next == '0);
                r_ovf       <= (r_a_msb == r_b_msb) & (w_s8[BYTE_W-1] != r_a_msb);
                r_out_valid <= 1'b1;
            end
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
